// File: rtl/nibble_serial_adder_pkg.sv
// Shared FSM state encoding and nibble width for the nibble-serial adder.
package nibble_serial_adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// RCA_4bit: 4-bit ripple-carry adder used as the per-cycle datapath slice.
module RCA_4bit
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial wide adder: NIBBLES*4-bit operands summed four bits per cycle.
// Define NIBBLE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NIB_W*NIBBLES-1:0]   a,
    input  logic [NIB_W*NIBBLES-1:0]   b,
    input  logic                       c_in,
    output logic                       busy,
    output logic                       done,
    output logic [NIB_W*NIBBLES-1:0]   sum,
    output logic                       c_out
`ifdef NIBBLE_ADDER_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int W  = NIB_W * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state;
    logic [W-1:0]     a_sh;
    logic [W-1:0]     b_sh;
    logic [W-1:0]     sum_sh;
    logic [W-1:0]     sum_sh_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    RCA_4bit u_rca (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // New nibble enters at the MSB end; the shift through the wider concat keeps NIBBLES=1 legal.
    always_comb begin
        sum_sh_next = W'({nib_sum, sum_sh} >> NIB_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= c_in;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_sh <= sum_sh_next;
                    carry  <= nib_cout;
                    a_sh   <= a_sh >> NIB_W;
                    b_sh   <= b_sh >> NIB_W;
                    count  <= count + 1'b1;
                    if (count == CW'(NIBBLES - 1)) begin
                        sum   <= sum_sh_next;
                        c_out <= nib_cout;
`ifdef NIBBLE_ADDER_OVF_EN
                        // Top nibble is in the low slice now, so bit 3 is each operand's MSB.
                        ovf   <= a_sh[NIB_W-1] ^ b_sh[NIB_W-1] ^ nib_sum[NIB_W-1] ^ nib_cout;
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
